modular_inverse_param: RTL and testbench

//  Parametrised prime-field modular inverse. It computes out = a^-1 mod p using the binary extended Euclidean algorithm.

---
 rtl/ec_pkg.sv | 20 ++
 rtl/mod_sub_p.sv | 20 ++
 rtl/modular_inverse_param.sv | 187 ++++++++++++++++++
 tb/tb_modular_inverse_param.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ec_pkg.sv
// Shared types for the modular inverse unit: FSM states and error codes.
package ec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TEST,
    HALF_U,
    HALF_V,
    SUB,
    DONE
  } modinv_state_t;

  typedef enum logic [1:0] {
    OK     = 2'd0,
    ZERO   = 2'd1,
    BADARG = 2'd2,
    NOINV  = 2'd3
  } modinv_err_t;

endpackage

// File: rtl/mod_sub_p.sv
// Combinational modular subtraction: diff_c = (x - y) mod p, for x, y in [0, p-1].
// Ports: x, y  minuend / subtrahend (W bits)
//        p     modulus (W bits)
//        diff_c  result in [0, p-1]
module mod_sub_p #(
  parameter int unsigned W = 256
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] p,
  output logic [W-1:0] diff_c
);

  logic [W:0] d;

  // The extra top bit is the borrow; on borrow add p back (wraps modulo 2^W).
  assign d      = {1'b0, x} - {1'b0, y};
  assign diff_c = d[W] ? (d[W-1:0] + p) : d[W-1:0];

endmodule

// File: rtl/modular_inverse_param.sv
// Prime-field modular inverse out = a^-1 mod p via the binary extended Euclidean
// algorithm; p is a run-time operand so one instance serves any odd modulus.
// Ports: clk, Reset_n (async active-low)
//        in_valid/in_ready  operand handshake (a, p), ready only in IDLE
//        out_valid/out_ready result handshake (out, err), result held until accepted
//        err: 0 OK, 1 ZERO, 2 BADARG, 3 NOINV (or TIMEOUT with watchdog)
// Optional: define MODINV_WATCHDOG_EN to abort after MAX_CYC working cycles.
module modular_inverse_param
  import ec_pkg::*;
#(
  parameter int unsigned W       = 256,
  parameter int unsigned MAX_CYC = 4 * W + 8
) (
  input  logic         clk,
  input  logic         Reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] p,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out,
  output logic [1:0]   err
);

  localparam int unsigned CW = $clog2(MAX_CYC + 1);

  modinv_state_t state, state_nx;
  modinv_err_t   err_q, err_nx;
  logic [W-1:0]  u, v, u_nx, v_nx, p_r, p_nx, res_nx;
  logic [W:0]    x1, x2, x1_nx, x2_nx, x1_half, x2_half;
  logic [W-1:0]  sub_x, sub_y, sub_diff;
  logic          u_ge_v;

  // Halving step: keep x congruent to u/2 by adding p first when x is odd.
  assign x1_half = x1[0] ? ((x1 + {1'b0, p_r}) >> 1) : (x1 >> 1);
  assign x2_half = x2[0] ? ((x2 + {1'b0, p_r}) >> 1) : (x2 >> 1);

  // Single shared subtractor, operands swapped depending on which of u/v shrinks.
  assign u_ge_v = (u >= v);
  assign sub_x  = u_ge_v ? x1[W-1:0] : x2[W-1:0];
  assign sub_y  = u_ge_v ? x2[W-1:0] : x1[W-1:0];

  mod_sub_p #(.W(W)) u_mod_sub (
    .x      (sub_x),
    .y      (sub_y),
    .p      (p_r),
    .diff_c (sub_diff)
  );

`ifdef MODINV_WATCHDOG_EN
  logic [CW-1:0] cyc, cyc_nx;
`else
  // Without the watchdog the limit is not needed.
  logic [CW-1:0] unused_cyc_lim;
  assign unused_cyc_lim = CW'(MAX_CYC);
`endif

  // Next-state and datapath update.
  always_comb begin
    state_nx = state;
    u_nx     = u;
    v_nx     = v;
    x1_nx    = x1;
    x2_nx    = x2;
    p_nx     = p_r;
    res_nx   = out;
    err_nx   = err_q;
`ifdef MODINV_WATCHDOG_EN
    cyc_nx   = cyc;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          u_nx   = a;
          v_nx   = p;
          x1_nx  = (W+1)'(1);
          x2_nx  = '0;
          p_nx   = p;
          res_nx = '0;
          err_nx = OK;
`ifdef MODINV_WATCHDOG_EN
          cyc_nx = '0;
`endif
          if (a == '0) begin
            state_nx = DONE;
            err_nx   = ZERO;
          end else if (!p[0] || (p <= W'(1)) || (a >= p)) begin
            state_nx = DONE;
            err_nx   = BADARG;
          end else begin
            state_nx = TEST;
          end
        end
      end
      TEST: begin
        if (u == W'(1)) begin
          state_nx = DONE;
          res_nx   = x1[W-1:0];
        end else if (v == W'(1)) begin
          state_nx = DONE;
          res_nx   = x2[W-1:0];
        end else if ((u == '0) || (v == '0)) begin
          state_nx = DONE;
          err_nx   = NOINV;
        end else if (!u[0]) begin
          state_nx = HALF_U;
        end else if (!v[0]) begin
          state_nx = HALF_V;
        end else begin
          state_nx = SUB;
        end
      end
      HALF_U: begin
        u_nx  = u >> 1;
        x1_nx = x1_half;
        if (u[1] || (u[W-1:1] == '0)) state_nx = TEST;
      end
      HALF_V: begin
        v_nx  = v >> 1;
        x2_nx = x2_half;
        if (v[1] || (v[W-1:1] == '0)) state_nx = TEST;
      end
      SUB: begin
        if (u_ge_v) begin
          u_nx  = u - v;
          x1_nx = {1'b0, sub_diff};
        end else begin
          v_nx  = v - u;
          x2_nx = {1'b0, sub_diff};
        end
        state_nx = TEST;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
`ifdef MODINV_WATCHDOG_EN
    // Timeout on the working cycle that brings the counter to MAX_CYC.
    if ((state == TEST) || (state == HALF_U) || (state == HALF_V) || (state == SUB)) begin
      cyc_nx = cyc + CW'(1);
      if ((state_nx != DONE) && (cyc_nx >= CW'(MAX_CYC))) begin
        state_nx = DONE;
        err_nx   = NOINV;
        res_nx   = '0;
      end
    end
`endif
  end

  // State and datapath registers; handshake flags track the next state.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      u         <= '0;
      v         <= '0;
      x1        <= '0;
      x2        <= '0;
      p_r       <= '0;
      out       <= '0;
      err_q     <= OK;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef MODINV_WATCHDOG_EN
      cyc       <= '0;
`endif
    end else begin
      state     <= state_nx;
      u         <= u_nx;
      v         <= v_nx;
      x1        <= x1_nx;
      x2        <= x2_nx;
      p_r       <= p_nx;
      out       <= res_nx;
      err_q     <= err_nx;
      out_valid <= (state_nx == DONE);
      in_ready  <= (state_nx == IDLE);
`ifdef MODINV_WATCHDOG_EN
      cyc       <= cyc_nx;
`endif
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_modular_inverse_param.sv
// Directed bench for modular_inverse_param: small hand-worked cases, handshake
// hold, async reset mid-operation and random inverses modulo the secp256k1 prime.
module tb_modular_inverse_param;

  localparam int unsigned W       = 256;
  localparam int          LAT_MAX = 4 * W + 4;
  localparam logic [W-1:0] P_K1 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic         clk = 1'b0;
  logic         Reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] p;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic [1:0]   err;

  int n_cmp  = 0;
  int n_fail = 0;

  modular_inverse_param #(.W(W)) dut (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .p         (p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Issue one operand, wait (bounded) for the result, then accept it.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tp,
                        output logic [W-1:0] r, output logic [1:0] e, output int lat);
    a        = ta;
    p        = tp;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < LAT_MAX + 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("result_arrives", W'(out_valid), W'(1));
    r = out;
    e = err;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0]   r, ra;
    logic [1:0]     e;
    logic [2*W-1:0] prod;
    int             lat;

    Reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    p         = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready",  W'(in_ready),  W'(1));
    chk("rst_out",       out,           W'(0));
    chk("rst_err",       W'(err),       W'(0));
    Reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(W'(3), W'(7), r, e, lat);
    chk("p7a3_out", r, W'(5));
    chk("p7a3_err", W'(e), W'(0));

    run_op(W'(1), W'(7), r, e, lat);
    chk("p7a1_out", r, W'(1));
    chk("p7a1_lat", W'(lat), W'(2));

    run_op(W'(0), W'(7), r, e, lat);
    chk("zero_err", W'(e), W'(1));
    chk("zero_out", r, W'(0));

    run_op(W'(9), W'(7), r, e, lat);
    chk("a_ge_p_err", W'(e), W'(2));
    chk("a_ge_p_out", r, W'(0));

    run_op(W'(3), W'(8), r, e, lat);
    chk("p_even_err", W'(e), W'(2));

    run_op(W'(3), W'(1), r, e, lat);
    chk("p_one_err", W'(e), W'(2));

    run_op(W'(5), W'(15), r, e, lat);
    chk("noinv_err", W'(e), W'(3));
    chk("noinv_out", r, W'(0));
    chk("noinv_lat", W'(lat <= LAT_MAX), W'(1));

    run_op(W'(2), W'(15), r, e, lat);
    chk("p15a2_out", r, W'(8));
    chk("p15a2_err", W'(e), W'(0));

    // Back-pressure: result must hold while out_ready is low.
    a        = W'(3);
    p        = W'(7);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < LAT_MAX + 20) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", W'(out_valid), W'(1));
      chk("hold_out",   out,           W'(5));
      chk("hold_err",   W'(err),       W'(0));
      chk("hold_ready", W'(in_ready),  W'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_valid", W'(out_valid), W'(0));
    chk("release_ready", W'(in_ready),  W'(1));

    // Reset during a long HALF_U run (a = 256 needs 8 halvings).
    a        = W'(256);
    p        = W'(65521);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", W'(in_ready), W'(0));
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", W'(out_valid), W'(0));
    chk("mid_rst_ready", W'(in_ready),  W'(1));
    @(posedge clk); #1;
    Reset_n = 1'b1;
    @(posedge clk); #1;
    run_op(W'(3), W'(7), r, e, lat);
    chk("post_rst_out", r, W'(5));
    chk("post_rst_err", W'(e), W'(0));

    // Random operands modulo the secp256k1 prime.
    for (int n = 0; n < 40; n++) begin
      ra = '0;
      for (int k = 0; k < 8; k++) ra = {ra[W-33:0], 32'($urandom)};
      ra = ra % P_K1;
      if (ra == '0) ra = W'(1);
      run_op(ra, P_K1, r, e, lat);
      prod = {{W{1'b0}}, ra} * {{W{1'b0}}, r};
      prod = prod % {{W{1'b0}}, P_K1};
      chk("k1_err", W'(e), W'(0));
      chk("k1_inv", W'(prod), W'(1));
      chk("k1_lat", W'(lat <= LAT_MAX), W'(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
